// File: rtl/dmem_responder_if.sv
// Memory-stage bus between the pipelined core and its data-memory responder.
// The core drives requests; the responder returns load data, stall and error.
interface dmem_responder_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        Enable;
  logic        MemErr;

  modport master (
    output MemReadM,
    output MemWriteM,
    output ALUOutM,
    output WriteDataM,
    input  ReadDataM,
    input  Enable,
    input  MemErr
  );

  modport slave (
    input  MemReadM,
    input  MemWriteM,
    input  ALUOutM,
    input  WriteDataM,
    output ReadDataM,
    output Enable,
    output MemErr
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the M stage: posted stores, loads stall
// the whole pipeline for LATENCY cycles through Enable.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        en;
  logic        we;
  logic        capture;
  logic        legal;
  logic        rd_req;
  logic        wr_req;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign idx    = bus.ALUOutM[AW+1:2];
  assign legal  = (bus.ALUOutM[1:0] == 2'b00) &&
                  ((bus.ALUOutM >> (AW + 2)) == 32'h0);
  // A simultaneous read+write request is resolved as a store.
  assign wr_req = bus.MemWriteM;
  assign rd_req = bus.MemReadM && !bus.MemWriteM;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    en      = 1'b1;
    we      = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          we = legal;
          if (!legal || bus.MemReadM) begin
            err_d = 1'b1;
          end
        end else if (rd_req) begin
          en      = 1'b0;
          count_d = 4'(LATENCY - 1);
          if (!legal) begin
            err_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = DONE;
            capture = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        en      = 1'b0;
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = DONE;
          capture = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Address is sampled at DONE entry; the core holds it while stalled.
    if (capture) begin
      rdata_d = legal ? mem[idx] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[idx] <= bus.WriteDataM;
    end
  end

  assign bus.Enable    = en;
  assign bus.ReadDataM = rdata_q;
  assign bus.MemErr    = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY 1, 3 and 4.
// All three instances see the same bus stimulus.
module tb_dmem_responder;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [31:0] a   = 32'h0;
  logic [31:0] wd  = 32'h0;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  dmem_responder_if b1 ();
  dmem_responder_if b3 ();
  dmem_responder_if b4 ();

  assign b1.MemReadM   = rd;
  assign b1.MemWriteM  = wr;
  assign b1.ALUOutM    = a;
  assign b1.WriteDataM = wd;
  assign b3.MemReadM   = rd;
  assign b3.MemWriteM  = wr;
  assign b3.ALUOutM    = a;
  assign b3.WriteDataM = wd;
  assign b4.MemReadM   = rd;
  assign b4.MemWriteM  = wr;
  assign b4.ALUOutM    = a;
  assign b4.WriteDataM = wd;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .reset(rst), .bus(b1)
  );
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u3 (
    .clk(clk), .reset(rst), .bus(b3)
  );
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u4 (
    .clk(clk), .reset(rst), .bus(b4)
  );

  function automatic logic en_of(int s);
    case (s)
      1:       return b1.Enable;
      3:       return b3.Enable;
      default: return b4.Enable;
    endcase
  endfunction

  function automatic logic [31:0] rd_of(int s);
    case (s)
      1:       return b1.ReadDataM;
      3:       return b3.ReadDataM;
      default: return b4.ReadDataM;
    endcase
  endfunction

  function automatic logic err_of(int s);
    case (s)
      1:       return b1.MemErr;
      3:       return b3.MemErr;
      default: return b4.MemErr;
    endcase
  endfunction

  function automatic bit legal(logic [31:0] x);
    return (x[1:0] == 2'b00) && (x < DEPTH * 4);
  endfunction

  task automatic idle(int n);
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rd  = 1'b0;
    wr  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic store(int s, logic [31:0] ad, logic [31:0] d);
    @(negedge clk);
    wr = 1'b1;
    rd = 1'b0;
    a  = ad;
    wd = d;
    if (legal(ad)) model[ad[7:2]] = d;
    #1;
    vecs++;
    if (en_of(s) !== 1'b1) begin
      errs++;
      $display("FAIL store_en u%0d @%h: got %b want 1",
               s, ad, en_of(s));
    end
  endtask

  task automatic do_load(int s, logic [31:0] ad, int lat, bit hold,
                         output int c_first, output int c_done);
    int st = 0;
    bit done = 1'b0;
    logic [31:0] e;
    exp_q.push_back(legal(ad) ? model[ad[7:2]] : 32'h0);
    @(negedge clk);
    rd = 1'b1;
    wr = 1'b0;
    a  = ad;
    #1;
    c_first = cyc;
    for (int k = 0; k < 40 && !done; k++) begin
      if (en_of(s) === 1'b1) begin
        done = 1'b1;
      end else begin
        st++;
        @(negedge clk);
        #1;
      end
    end
    c_done = cyc;
    vecs++;
    if (!done) begin
      errs++;
      $display("FAIL load_timeout u%0d @%h: no DONE in 40 cycles",
               s, ad);
    end
    vecs++;
    if (st !== lat) begin
      errs++;
      $display("FAIL stall_len u%0d @%h: got %0d want %0d",
               s, ad, st, lat);
    end
    e = exp_q.pop_front();
    vecs++;
    if (rd_of(s) !== e) begin
      errs++;
      $display("FAIL rdata u%0d @%h: got %h want %h",
               s, ad, rd_of(s), e);
    end
    if (!hold) rd = 1'b0;
  endtask

  task automatic test_reset();
    int ids [3] = '{1, 3, 4};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    foreach (ids[i]) begin
      vecs++;
      if (en_of(ids[i]) !== 1'b1) begin
        errs++;
        $display("FAIL rst_en u%0d: got %b want 1",
                 ids[i], en_of(ids[i]));
      end
      vecs++;
      if (rd_of(ids[i]) !== 32'h0) begin
        errs++;
        $display("FAIL rst_rdata u%0d: got %h want 0",
                 ids[i], rd_of(ids[i]));
      end
      vecs++;
      if (err_of(ids[i]) !== 1'b0) begin
        errs++;
        $display("FAIL rst_err u%0d: got %b want 0",
                 ids[i], err_of(ids[i]));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    int f, d;
    store(3, 32'h10, 32'hDEADBEEF);
    idle(6);
    do_load(3, 32'h10, 3, 1'b0, f, d);
    vecs++;
    if (err_of(3) !== 1'b0) begin
      errs++;
      $display("FAIL sl_err: got %b want 0", err_of(3));
    end
    idle(6);
    #1;
    vecs++;
    if (rd_of(3) !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL sl_hold: got %h want deadbeef", rd_of(3));
    end
  endtask

  task automatic test_consecutive();
    int f, d;
    store(3, 32'h0, 32'h11111111);
    store(3, 32'h4, 32'h22222222);
    store(3, 32'h8, 32'h33333333);
    idle(6);
    do_load(3, 32'h0, 3, 1'b0, f, d);
    idle(6);
    do_load(3, 32'h4, 3, 1'b0, f, d);
    idle(6);
    do_load(3, 32'h8, 3, 1'b0, f, d);
    idle(6);
  endtask

  task automatic test_back_to_back();
    int f1, d1, f2, d2;
    do_load(1, 32'h4, 1, 1'b1, f1, d1);
    do_load(1, 32'h8, 1, 1'b0, f2, d2);
    vecs++;
    if (d2 - f1 !== 3) begin
      errs++;
      $display("FAIL b2b_span: got %0d cycles want 3", d2 - f1);
    end
    idle(6);
  endtask

  task automatic test_reset_busy();
    int f, d;
    @(negedge clk);
    rd = 1'b1;
    a  = 32'h10;
    @(negedge clk);
    #1;
    vecs++;
    if (en_of(4) !== 1'b0) begin
      errs++;
      $display("FAIL rb_stall: got %b want 0", en_of(4));
    end
    rst = 1'b1;
    rd  = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    vecs++;
    if (en_of(4) !== 1'b1) begin
      errs++;
      $display("FAIL rb_en: got %b want 1", en_of(4));
    end
    vecs++;
    if (rd_of(4) !== 32'h0) begin
      errs++;
      $display("FAIL rb_rdata: got %h want 0", rd_of(4));
    end
    vecs++;
    if (err_of(4) !== 1'b0) begin
      errs++;
      $display("FAIL rb_err: got %b want 0", err_of(4));
    end
    idle(6);
    do_load(4, 32'h10, 4, 1'b0, f, d);
    idle(6);
  endtask

  task automatic test_out_of_range();
    int f, d;
    do_load(3, DEPTH * 4, 3, 1'b0, f, d);
    vecs++;
    if (err_of(3) !== 1'b1) begin
      errs++;
      $display("FAIL oor_err: got %b want 1", err_of(3));
    end
    idle(6);
  endtask

  task automatic test_misaligned();
    int f, d;
    do_reset();
    #1;
    vecs++;
    if (err_of(3) !== 1'b0) begin
      errs++;
      $display("FAIL mis_pre_err: got %b want 0", err_of(3));
    end
    store(3, 32'h13, 32'h00001234);
    idle(6);
    #1;
    vecs++;
    if (err_of(3) !== 1'b1) begin
      errs++;
      $display("FAIL mis_err: got %b want 1", err_of(3));
    end
    do_load(3, 32'h10, 3, 1'b0, f, d);
    idle(6);
  endtask

  task automatic test_both();
    int f, d;
    do_reset();
    @(negedge clk);
    rd = 1'b1;
    wr = 1'b1;
    a  = 32'h20;
    wd = 32'hCAFEF00D;
    model[8] = 32'hCAFEF00D;
    #1;
    vecs++;
    if (en_of(3) !== 1'b1) begin
      errs++;
      $display("FAIL both_en: got %b want 1", en_of(3));
    end
    idle(6);
    #1;
    vecs++;
    if (err_of(3) !== 1'b1) begin
      errs++;
      $display("FAIL both_err: got %b want 1", err_of(3));
    end
    do_load(3, 32'h20, 3, 1'b0, f, d);
    idle(6);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_consecutive();
    test_back_to_back();
    test_reset_busy();
    test_out_of_range();
    test_misaligned();
    test_both();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
